// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file.
// Optional macro REGFILE_BYPASS_EN selects write-first forwarding on read ports.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_DEPTH  = 32;
  localparam int unsigned DEF_ADDR_W = $clog2(DEF_DEPTH);
  localparam int unsigned ZERO_REG   = 0;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_WIDTH-1:0]  reg_data_t;

  // Address width for a given depth; a single-entry file still needs one address bit
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/register_file_read_port.sv
// One synchronous read port: zero/out-of-range masking, optional bypass, output register.
// REGFILE_BYPASS_EN defined: a same-edge write to the read address is forwarded (write-first).
module register_file_read_port
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH  = DEF_WIDTH,
  parameter  int unsigned DEPTH  = DEF_DEPTH,
  localparam int unsigned ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              write,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [WIDTH-1:0]  mem [DEPTH],
  output logic [WIDTH-1:0]  data_out
);

  logic             addr_ok;
  logic [WIDTH-1:0] rd_data;

  // Entry 0 and addresses past the last entry always read as zero
  always_comb begin
    addr_ok = (rd_addr != ADDR_W'(ZERO_REG)) && (32'(rd_addr) < DEPTH);
    rd_data = '0;
    if (addr_ok) begin
      rd_data = mem[rd_addr];
    end
`ifdef REGFILE_BYPASS_EN
    if (addr_ok && write && (wr_addr == rd_addr)) begin
      rd_data = data_in;
    end
`endif
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{write, wr_addr, data_in};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (enable) begin
      data_out <= rd_data;
    end
  end

endmodule

// File: rtl/register_file.sv
// Register file: one write port, two registered read ports, entry 0 hardwired to zero.
// Optional macro REGFILE_BYPASS_EN makes same-edge write/read hits return the new data.
module register_file
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH  = DEF_WIDTH,
  parameter  int unsigned DEPTH  = DEF_DEPTH,
  localparam int unsigned ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              enable,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  data_out_a,
  output logic [WIDTH-1:0]  data_out_b,
  output logic              rd_valid
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;

  assign wr_ok = write && (wr_addr != ADDR_W'(ZERO_REG)) && (32'(wr_addr) < DEPTH);

  // Storage; writes to entry 0 or past the end are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[wr_addr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= enable;
    end
  end

  register_file_read_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_port_a (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .rd_addr  (rd_addr_a),
    .write    (write),
    .wr_addr  (wr_addr),
    .data_in  (data_in),
    .mem      (mem),
    .data_out (data_out_a)
  );

  register_file_read_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_port_b (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .rd_addr  (rd_addr_b),
    .write    (write),
    .wr_addr  (wr_addr),
    .data_in  (data_in),
    .mem      (mem),
    .data_out (data_out_b)
  );

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file at WIDTH=16, DEPTH=20 (exercises out-of-range addresses).
// Honours REGFILE_BYPASS_EN for the same-edge collision expectation.
module tb_register_file;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 20;
  localparam int unsigned AW = 5;

`ifdef REGFILE_BYPASS_EN
  localparam logic [W-1:0] COLL_EXP = 16'd10;
`else
  localparam logic [W-1:0] COLL_EXP = 16'd30;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          write;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  data_in;
  logic          enable;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [W-1:0]  data_out_a;
  logic [W-1:0]  data_out_b;
  logic          rd_valid;

  int total = 0;
  int bad   = 0;

  register_file #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .write      (write),
    .wr_addr    (wr_addr),
    .data_in    (data_in),
    .enable     (enable),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .data_out_a (data_out_a),
    .data_out_b (data_out_b),
    .rd_valid   (rd_valid)
  );

  always #5 clk = ~clk;

  // Reference model: plain array plus expected outputs
  logic [W-1:0] mm [D];
  logic [W-1:0] exp_a;
  logic [W-1:0] exp_b;
  logic         exp_v;

  function automatic logic [W-1:0] model_read(input logic [AW-1:0] ra);
    if (ra == 0 || 32'(ra) >= D) return '0;
`ifdef REGFILE_BYPASS_EN
    if (write && wr_addr == ra) return data_in;
`endif
    return mm[ra];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(D); i++) mm[i] = '0;
      exp_a = '0;
      exp_b = '0;
      exp_v = 1'b0;
    end else begin
      if (enable) begin
        exp_a = model_read(rd_addr_a);
        exp_b = model_read(rd_addr_b);
      end
      exp_v = enable;
      if (write && wr_addr != 0 && 32'(wr_addr) < D) mm[wr_addr] = data_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("cyc_data_out_a", 32'(data_out_a), 32'(exp_a));
    chk("cyc_data_out_b", 32'(data_out_b), 32'(exp_b));
    chk("cyc_rd_valid", 32'(rd_valid), 32'(exp_v));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic en, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    write = w; wr_addr = wa; data_in = wd;
    enable = en; rd_addr_a = ra; rd_addr_b = rb;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    chk("reset_a", 32'(data_out_a), 32'd0);
    chk("reset_b", 32'(data_out_b), 32'd0);
    chk("reset_valid", 32'(rd_valid), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // Write 5 <= 25, then read A=5, B=0
    drive(1'b1, 5'd5, 16'd25, 1'b0, '0, '0);
    step();
    drive(1'b0, '0, '0, 1'b1, 5'd5, 5'd0);
    step();
    chk("wr_rd_a", 32'(data_out_a), 32'd25);
    chk("wr_rd_b", 32'(data_out_b), 32'd0);
    chk("wr_rd_valid", 32'(rd_valid), 32'd1);

    // Hold for 3 cycles while 5 is rewritten with 62
    drive(1'b1, 5'd5, 16'd62, 1'b0, 5'd5, 5'd5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_a", 32'(data_out_a), 32'd25);
      chk("hold_valid", 32'(rd_valid), 32'd0);
      write = 1'b0;
    end
    drive(1'b0, '0, '0, 1'b1, 5'd5, 5'd5);
    step();
    chk("hold_new_a", 32'(data_out_a), 32'd62);

    // Write to entry 0 is ignored and entry 0 reads zero
    drive(1'b1, 5'd0, 16'd40, 1'b1, 5'd0, 5'd5);
    step();
    chk("zero_reg_a", 32'(data_out_a), 32'd0);
    chk("zero_reg_b", 32'(data_out_b), 32'd62);

    // Same-edge collision on entry 7
    drive(1'b1, 5'd7, 16'd30, 1'b0, '0, '0);
    step();
    drive(1'b1, 5'd7, 16'd10, 1'b1, 5'd7, 5'd7);
    step();
    chk("coll_a", 32'(data_out_a), 32'(COLL_EXP));
    chk("coll_b", 32'(data_out_b), 32'(COLL_EXP));
    drive(1'b0, '0, '0, 1'b1, 5'd7, 5'd7);
    step();
    chk("coll_after_a", 32'(data_out_a), 32'd10);

    // Out-of-range write/read
    drive(1'b1, 5'd25, 16'd99, 1'b1, 5'd25, 5'd5);
    step();
    chk("range_a", 32'(data_out_a), 32'd0);
    chk("range_b", 32'(data_out_b), 32'd62);
    for (int i = 1; i < int'(D); i++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(i), AW'(i));
      step();
      chk("range_scan", 32'(data_out_a), (i == 5) ? 32'd62 : (i == 7) ? 32'd10 : 32'd0);
    end

    // Last valid entry versus first invalid one
    drive(1'b1, 5'd19, 16'hbeef, 1'b0, '0, '0);
    step();
    drive(1'b1, 5'd20, 16'h1234, 1'b1, 5'd19, 5'd20);
    step();
    chk("last_entry_a", 32'(data_out_a), 32'h0000beef);
    chk("past_end_b", 32'(data_out_b), 32'd0);

    // Back-to-back write and read every cycle
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, AW'($urandom_range(0, 31)), W'($urandom), 1'b1,
            AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
      if (i % 4 == 0) rd_addr_a = wr_addr;
      step();
    end

    // Async reset in the middle of a read
    drive(1'b0, '0, '0, 1'b1, 5'd5, 5'd19);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_a", 32'(data_out_a), 32'd0);
    chk("mid_rst_b", 32'(data_out_b), 32'd0);
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    step();
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b1, 5'd5, 5'd19);
    step();
    chk("post_rst_a", 32'(data_out_a), 32'd0);
    chk("post_rst_b", 32'(data_out_b), 32'd0);
    chk("post_rst_valid", 32'(rd_valid), 32'd1);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
